// File: rtl/montgomery_constant_server.sv
`default_nettype none
// ============================================================================
//  Module   : montgomery_constant_server
//  Purpose  : Block-serial store/server for Montgomery constants N and k.
//  Option   : MONT_CONST_PASS_CTR_EN adds saturating per-channel pass counters.
//  Revision : 1.0 - initial release
// ============================================================================
module montgomery_constant_server #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 4096
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     load_valid_in,
  input  logic                     load_sel_in,
  input  logic [REGISTER_SIZE-1:0] load_block_in,
  input  logic                     restart_in,
  input  logic                     consumed_N_in,
  input  logic                     consumed_k_in,
  output logic [REGISTER_SIZE-1:0] N_out,
  output logic [REGISTER_SIZE-1:0] k_out,
  output logic                     ready_out,
  output logic [15:0]              N_passes_out,
  output logic [15:0]              k_passes_out
);

  localparam int NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int c_ptr_w    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(NUM_BLOCKS - 1);
  localparam logic [c_ptr_w-1:0] c_one  = c_ptr_w'(1);

  // Asynchronous assertion, two-flop synchronous release.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  logic [1:0] w_consume;
  assign w_consume = {consumed_k_in, consumed_N_in};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [REGISTER_SIZE-1:0] r_mem [NUM_BLOCKS];
    logic [c_ptr_w-1:0]       r_wr_ptr;
    logic [c_ptr_w-1:0]       r_rd_ptr;
    logic [c_ptr_w-1:0]       w_wr_ptr_nxt;
    logic [c_ptr_w-1:0]       w_rd_ptr_nxt;
    logic                     r_loaded;
    logic                     w_loaded_nxt;
    logic [REGISTER_SIZE-1:0] r_out;
    logic [REGISTER_SIZE-1:0] w_rd_data;
    logic [15:0]              w_passes;
    logic                     w_wr;
    logic                     w_first;
    logic                     w_last;
    logic                     w_clr;
    logic                     w_adv;

    assign w_wr    = load_valid_in && (load_sel_in == (ch == 1));
    assign w_first = w_wr && (r_wr_ptr == '0);
    assign w_last  = w_wr && (r_wr_ptr == c_last);
    assign w_clr   = w_first || restart_in;
    assign w_adv   = w_consume[ch] && r_loaded && !w_clr;

    always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      if (w_wr) begin
        w_wr_ptr_nxt = w_last ? '0 : r_wr_ptr + c_one;
      end

      w_loaded_nxt = r_loaded;
      if (w_last) begin
        w_loaded_nxt = 1'b1;
      end else if (w_first) begin
        w_loaded_nxt = 1'b0;
      end

      w_rd_ptr_nxt = r_rd_ptr;
      if (w_clr) begin
        w_rd_ptr_nxt = '0;
      end else if (w_adv) begin
        w_rd_ptr_nxt = (r_rd_ptr == c_last) ? '0 : r_rd_ptr + c_one;
      end
    end

    // Output register is fed by the next pointer so a consume at edge t
    // presents the following block at t+1; bypass covers a same-edge write.
    assign w_rd_data = (w_wr && (r_wr_ptr == w_rd_ptr_nxt)) ? load_block_in
                                                            : r_mem[w_rd_ptr_nxt];

    always_ff @(posedge clk_in) begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= load_block_in;
      end
    end

    always_ff @(posedge clk_in or negedge w_rst_n) begin
      if (!w_rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_loaded <= 1'b0;
        r_out    <= '0;
      end else begin
        r_wr_ptr <= w_wr_ptr_nxt;
        r_rd_ptr <= w_rd_ptr_nxt;
        r_loaded <= w_loaded_nxt;
        r_out    <= w_loaded_nxt ? w_rd_data : '0;
      end
    end

`ifdef MONT_CONST_PASS_CTR_EN
    logic [15:0] r_passes;

    always_ff @(posedge clk_in or negedge w_rst_n) begin
      if (!w_rst_n) begin
        r_passes <= '0;
      end else if (w_clr) begin
        r_passes <= '0;
      end else if (w_adv && (r_rd_ptr == c_last) && (r_passes != 16'hFFFF)) begin
        r_passes <= r_passes + 16'd1;
      end
    end

    assign w_passes = r_passes;
`else
    assign w_passes = 16'h0000;
`endif
  end

  assign N_out        = g_chan[0].r_out;
  assign k_out        = g_chan[1].r_out;
  assign ready_out    = g_chan[0].r_loaded & g_chan[1].r_loaded;
  assign N_passes_out = g_chan[0].w_passes;
  assign k_passes_out = g_chan[1].w_passes;

endmodule
`default_nettype wire

// File: tb/tb_montgomery_constant_server.sv
`default_nettype none
// ============================================================================
//  Module   : tb_montgomery_constant_server
//  Purpose  : Directed self-checking bench, REGISTER_SIZE=8, BITS_IN_NUM=32.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_montgomery_constant_server;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       load_valid_in;
  logic       load_sel_in;
  logic [7:0] load_block_in;
  logic       restart_in;
  logic       consumed_N_in;
  logic       consumed_k_in;
  logic [7:0] N_out;
  logic [7:0] k_out;
  logic       ready_out;
  logic [15:0] N_passes_out;
  logic [15:0] k_passes_out;

  int n_vec  = 0;
  int n_miss = 0;

`ifdef MONT_CONST_PASS_CTR_EN
  localparam logic [15:0] c_one_pass = 16'd1;
`else
  localparam logic [15:0] c_one_pass = 16'd0;
`endif

  montgomery_constant_server #(
    .REGISTER_SIZE(8),
    .BITS_IN_NUM  (32)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .load_valid_in (load_valid_in),
    .load_sel_in   (load_sel_in),
    .load_block_in (load_block_in),
    .restart_in    (restart_in),
    .consumed_N_in (consumed_N_in),
    .consumed_k_in (consumed_k_in),
    .N_out         (N_out),
    .k_out         (k_out),
    .ready_out     (ready_out),
    .N_passes_out  (N_passes_out),
    .k_passes_out  (k_passes_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load_word(input logic sel, input logic [31:0] word);
    logic [31:0] w;
    w = word;
    for (int i = 0; i < 4; i++) begin
      load_valid_in = 1'b1;
      load_sel_in   = sel;
      load_block_in = w[8*i +: 8];
      tick();
    end
    load_valid_in = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_n [5];
    exp_n = '{8'h22, 8'h33, 8'h44, 8'h11, 8'h22};

    rst_in        = 1'b0;
    load_valid_in = 1'b0;
    load_sel_in   = 1'b0;
    load_block_in = 8'h00;
    restart_in    = 1'b0;
    consumed_N_in = 1'b0;
    consumed_k_in = 1'b0;

    repeat (2) tick();
    check_vec("rst_N_out", N_out, 0);
    check_vec("rst_k_out", k_out, 0);
    check_vec("rst_ready", ready_out, 0);
    rst_in = 1'b1;
    repeat (3) tick();

    // Consume before any load: ignored
    consumed_N_in = 1'b1;
    consumed_k_in = 1'b1;
    repeat (2) tick();
    consumed_N_in = 1'b0;
    consumed_k_in = 1'b0;
    check_vec("preload_N_out", N_out, 0);
    check_vec("preload_k_out", k_out, 0);
    check_vec("preload_ready", ready_out, 0);

    load_word(1'b0, 32'h44332211);
    check_vec("half_loaded_ready", ready_out, 0);
    check_vec("half_loaded_N_out", N_out, 8'h11);
    load_word(1'b1, 32'hDDCCBBAA);
    check_vec("loaded_ready", ready_out, 1);
    check_vec("loaded_N_out", N_out, 8'h11);
    check_vec("loaded_k_out", k_out, 8'hAA);

    consumed_N_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_vec($sformatf("streamN_%0d", i), N_out, exp_n[i]);
      check_vec($sformatf("streamN_k_%0d", i), k_out, 8'hAA);
    end
    consumed_N_in = 1'b0;
    check_vec("N_passes", N_passes_out, c_one_pass);
    check_vec("k_passes", k_passes_out, 0);

    restart_in = 1'b1;
    tick();
    restart_in = 1'b0;
    check_vec("restart_N_out", N_out, 8'h11);
    check_vec("restart_k_out", k_out, 8'hAA);
    check_vec("restart_N_passes", N_passes_out, 0);

    consumed_N_in = 1'b1;
    consumed_k_in = 1'b1;
    tick();
    check_vec("both1_N", N_out, 8'h22);
    check_vec("both1_k", k_out, 8'hBB);
    tick();
    check_vec("both2_N", N_out, 8'h33);
    check_vec("both2_k", k_out, 8'hCC);
    consumed_N_in = 1'b0;
    consumed_k_in = 1'b0;
    restart_in    = 1'b1;
    tick();
    restart_in = 1'b0;
    check_vec("restart2_N", N_out, 8'h11);
    check_vec("restart2_k", k_out, 8'hAA);

    // Reload N mid-run; block 0 wins over a same-cycle consume
    consumed_N_in = 1'b1;
    load_valid_in = 1'b1;
    load_sel_in   = 1'b0;
    load_block_in = 8'h99;
    tick();
    consumed_N_in = 1'b0;
    check_vec("reload_ready", ready_out, 0);
    check_vec("reload_N_out", N_out, 0);
    check_vec("reload_k_out", k_out, 8'hAA);
    load_block_in = 8'h98;
    tick();
    load_block_in = 8'h97;
    tick();
    check_vec("reload_mid_ready", ready_out, 0);
    load_block_in = 8'h96;
    tick();
    load_valid_in = 1'b0;
    check_vec("reloaded_ready", ready_out, 1);
    check_vec("reloaded_N_out", N_out, 8'h99);
    consumed_N_in = 1'b1;
    tick();
    check_vec("reloaded_next_N", N_out, 8'h98);

    // Asynchronous reset mid-consume
    #2;
    rst_in = 1'b0;
    #1;
    check_vec("async_rst_N_out", N_out, 0);
    check_vec("async_rst_k_out", k_out, 0);
    check_vec("async_rst_ready", ready_out, 0);
    consumed_N_in = 1'b0;
    tick();
    rst_in = 1'b1;
    repeat (4) tick();
    check_vec("post_rst_ready", ready_out, 0);
    check_vec("post_rst_N_out", N_out, 0);
    load_word(1'b0, 32'h0D0C0B0A);
    check_vec("post_rst_halfload_ready", ready_out, 0);
    load_word(1'b1, 32'h04030201);
    check_vec("post_rst_ready_again", ready_out, 1);
    check_vec("post_rst_N_block0", N_out, 8'h0A);
    check_vec("post_rst_k_block0", k_out, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/montgomery_constant_server.md
# montgomery_constant_server

Block-serial source for the Montgomery constants N and k (k = −N⁻¹ mod R) consumed by the Montgomery reduction and squarer stream.
- Holds both constants in on-chip storage, loaded once per key over a serial block port.
- Presents the current block of each constant on `N_out` / `k_out` and advances each channel independently on the consumer's `consumed_N_in` / `consumed_k_in` pulses, wrapping to block 0 after the last block.
- It is the responder end of the consume handshake driven by the reducer.

## Interface
- `REGISTER_SIZE`, 32, bits per block.
- `BITS_IN_NUM`, 4096, bits in N and in k (R = 2^BITS_IN_NUM).
- `NUM_BLOCKS`, BITS_IN_NUM/REGISTER_SIZE, blocks per constant (derived localparam).

Ports:
- `clk_in`  in  1  single clock; all logic in this domain.
- `rst_in`  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `load_valid_in`  in  1  a load block is present this cycle.
- `load_sel_in`  in  1  0 = block belongs to N, 1 = block belongs to k.
- `load_block_in`  in  REGISTER_SIZE  constant block, least-significant block first.
- `restart_in`  in  1  synchronous; returns both read pointers to block 0.
- `consumed_N_in`  in  1  consumer accepted current `N_out`.
- `consumed_k_in`  in  1  consumer accepted current `k_out`.
- `N_out`  out  REGISTER_SIZE  current N block.
- `k_out`  out  REGISTER_SIZE  current k block.
- `ready_out`  out  1  both constants fully loaded; outputs meaningful.

## Operation
- Per channel (N, k) the block keeps:
  - a write counter `wr_ptr` (0..NUM_BLOCKS-1);
  - a read pointer `rd_ptr` (0..NUM_BLOCKS-1);
  - a `loaded` flag.
- `ready_out` = `loaded_N & loaded_k`.
- **Load:**
  - On `load_valid_in`, write `load_block_in` to `mem[sel][wr_ptr]` and increment that channel's `wr_ptr`.
  - At NUM_BLOCKS-1, `wr_ptr` wraps to 0 and `loaded` is set.
  - The first block of a channel (`wr_ptr` == 0) clears that channel's `loaded` and sets its `rd_ptr` to 0, so reloading N or k mid-run deasserts `ready_out` until the reload completes.
- **Serve:**
  - `N_out` = `mem[N][rd_ptr_N]`; `k_out` = `mem[k][rd_ptr_k]`.
  - `consumed_x_in` increments `rd_ptr_x`, wrapping NUM_BLOCKS-1 → 0.
  - Channels are fully independent; both may consume in the same cycle.
- Consume pulses while that channel's `loaded` = 0 are ignored.
- **Priority per channel, highest first:**
  1. Reset.
  2. Load of block 0 to that channel.
  3. `restart_in`.
  4. Consume.
- A load to block >0 of a channel, simultaneous with consume on that same channel, is legal; both take effect, and the consume sees old data.
- Outputs are 0 whenever `loaded` = 0 for that channel.

## Timing
- **Reset values:** `N_out` = 0, `k_out` = 0, `ready_out` = 0; all pointers 0; `loaded` flags 0. Memory contents are undefined after reset and are masked by `loaded`.
- Reset asserts asynchronously and deasserts synchronously to `clk_in` (two-flop release inside the block).
- **Load:**
  - Writes take effect at the clock edge.
  - `ready_out` rises the cycle after the final block of the second channel is written.
- **Consume:**
  - `consumed_x_in` sampled at edge t.
  - `x_out` shows the next block from cycle t+1; back-to-back consumes every cycle are supported, giving one block per cycle with no bubbles.
  - Implementation uses a registered memory read addressed by the next-pointer value to meet this.
- `restart_in` at edge t → `N_out` / `k_out` show block 0 from t+1.
- No combinational path from any input to any output.

## Configuration
- `MONT_CONST_PASS_CTR_EN`
  - When defined, adds outputs `N_passes_out` and `k_passes_out` (16 bits each). Each increments, saturating at 0xFFFF, whenever its `rd_ptr` wraps NUM_BLOCKS-1 → 0 on a consume. Both are cleared by reset, `restart_in`, or a load of block 0 to that channel.
  - When undefined, the counter logic is absent and both ports are tied to 0.

## Test plan
All scenarios use REGISTER_SIZE=8, BITS_IN_NUM=32, NUM_BLOCKS=4.
1. Load N = 0x44332211, then k = 0xDDCCBBAA → `ready_out` = 1 one cycle after the 8th load. `N_out` = 0x11, `k_out` = 0xAA.
2. `consumed_N_in` held high for 5 cycles → `N_out` = 0x22, 0x33, 0x44, 0x11, 0x22. `k_out` stays 0xAA. `N_passes_out` = 1 if enabled.
3. Simultaneous `consumed_N_in` and `consumed_k_in` for 2 cycles, then `restart_in` → outputs 0x22/0xBB, 0x33/0xCC, then 0x11/0xAA.
4. Consume pulses before any load → `N_out` = `k_out` = 0, `ready_out` = 0. After loading, `N_out` = 0x11 (pulses ignored).
5. Mid-run, load N block 0 = 0x99 → `ready_out` = 0 the next cycle, `N_out` = 0. After 3 more N blocks, `ready_out` = 1 and `N_out` = 0x99.
6. Assert `rst_in` low asynchronously mid-consume → all outputs 0 immediately, before the next edge. After release, `ready_out` stays 0 until both channels are reloaded.
